// File: rtl/parking_sensor_emulator_if.sv
// Request/response and beam bundle between a pass requester and the sensor emulator.
// Handshake: a request is taken on any rising edge where the emulator is idle and some req_* is high; while busy=1 requests are dropped; done pulses one cycle at completion.
interface parking_sensor_emulator_if #(
    parameter int CNT_W = 8
);
    logic             req_in;
    logic             req_out;
    logic             req_balk;
    logic             sensor_a;
    logic             sensor_b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [2:0]       dbg_state;

    modport master (
        output req_in, req_out, req_balk,
        input  sensor_a, sensor_b, busy, done, in_cnt, out_cnt, dbg_state
    );

    modport slave (
        input  req_in, req_out, req_balk,
        output sensor_a, sensor_b, busy, done, in_cnt, out_cnt, dbg_state
    );
endinterface

// File: rtl/parking_sensor_emulator.sv
// Generates the active-low two-beam waveform of a car entering, exiting or balking,
// with registered outputs and wrap-around entry/exit tallies.
module parking_sensor_emulator #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    parking_sensor_emulator_if.slave bus
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_GAP} state_t;
    typedef enum logic [1:0] {DIR_IN, DIR_OUT, DIR_BALK} dir_t;

    state_t           state, state_n;
    dir_t             dir, dir_n;
    logic [TW-1:0]    timer, timer_n;
    logic             sensor_a_q, sensor_b_q, busy_q, done_q;
    logic             busy_n, done_n;
    logic [1:0]       ab_n;
    logic [CNT_W-1:0] in_cnt_q, out_cnt_q, in_cnt_n, out_cnt_n;

    always_comb begin
        state_n   = state;
        dir_n     = dir;
        timer_n   = timer;
        done_n    = 1'b0;
        in_cnt_n  = in_cnt_q;
        out_cnt_n = out_cnt_q;
        ab_n      = 2'b00;
        case (state)
            S_IDLE: begin
                if (bus.req_in || bus.req_out || bus.req_balk) begin
                    state_n = S_PH1;
                    timer_n = HOLD_LD;
                    if (bus.req_in)       dir_n = DIR_IN;
                    else if (bus.req_out) dir_n = DIR_OUT;
                    else                  dir_n = DIR_BALK;
                end
            end
            S_PH1: begin
                if (timer == '0) begin
                    // A balk backs out after blocking A only, so it skips the crossing phases.
                    if (dir == DIR_BALK) begin
                        state_n = S_GAP;
                        timer_n = GAP_LD;
                    end else begin
                        state_n = S_PH2;
                        timer_n = HOLD_LD;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_PH2: begin
                if (timer == '0) begin
                    state_n = S_PH3;
                    timer_n = HOLD_LD;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_PH3: begin
                if (timer == '0) begin
                    state_n = S_GAP;
                    timer_n = GAP_LD;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    if (dir == DIR_IN)  in_cnt_n  = in_cnt_q + CNT_W'(1);
                    if (dir == DIR_OUT) out_cnt_n = out_cnt_q + CNT_W'(1);
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Beam pattern {A,B} (1 = blocked) is decoded from the next state so the outputs can be registered.
        case (state_n)
            S_PH1:   ab_n = (dir_n == DIR_OUT) ? 2'b01 : 2'b10;
            S_PH2:   ab_n = 2'b11;
            S_PH3:   ab_n = (dir_n == DIR_OUT) ? 2'b10 : 2'b01;
            default: ab_n = 2'b00;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dir        <= DIR_IN;
            timer      <= '0;
            sensor_a_q <= 1'b1;
            sensor_b_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            timer      <= timer_n;
            sensor_a_q <= ~ab_n[1];
            sensor_b_q <= ~ab_n[0];
            busy_q     <= busy_n;
            done_q     <= done_n;
            in_cnt_q   <= in_cnt_n;
            out_cnt_q  <= out_cnt_n;
        end
    end

    assign bus.sensor_a  = sensor_a_q;
    assign bus.sensor_b  = sensor_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_cnt    = in_cnt_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Directed bench for the parking sensor emulator with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_parking_sensor_emulator;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int CNT_W = 8;

  localparam int K_IN   = 0;
  localparam int K_OUT  = 1;
  localparam int K_BALK = 2;
  localparam int K_ALL  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [CNT_W-1:0] exp_q[$];

  parking_sensor_emulator_if #(.CNT_W(CNT_W)) bus ();

  parking_sensor_emulator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {sensor_a, sensor_b, busy, done} for cycle c after the request cycle
  function automatic logic [3:0] exp_vec(input int kind, input int c);
    logic [1:0] ab;
    int last;
    last = (kind == K_BALK) ? 7 : 15;
    if (kind == K_BALK) begin
      ab = (c <= 4) ? 2'b01 : 2'b11;
    end else if (kind == K_OUT) begin
      if (c <= 4)       ab = 2'b10;
      else if (c <= 8)  ab = 2'b00;
      else if (c <= 12) ab = 2'b01;
      else              ab = 2'b11;
    end else begin
      if (c <= 4)       ab = 2'b01;
      else if (c <= 8)  ab = 2'b00;
      else if (c <= 12) ab = 2'b10;
      else              ab = 2'b11;
    end
    return {ab, (c < last), (c == last)};
  endfunction

  // driver: issue one request, then follow the pass to its done cycle; inj pulses req_in in that cycle
  task automatic run_pass(input int kind, input int inj, input string tag);
    int last;
    last = (kind == K_BALK) ? 7 : 15;
    bus.req_in   = (kind == K_IN)   || (kind == K_ALL);
    bus.req_out  = (kind == K_OUT)  || (kind == K_ALL);
    bus.req_balk = (kind == K_BALK) || (kind == K_ALL);
    for (int c = 1; c <= last; c++) begin
      tick();
      bus.req_in   = (c == inj);
      bus.req_out  = 1'b0;
      bus.req_balk = 1'b0;
      check($sformatf("%s_c%0d", tag, c),
            {28'd0, bus.sensor_a, bus.sensor_b, bus.busy, bus.done},
            {28'd0, exp_vec(kind, c)});
    end
  endtask

  initial begin
    int kinds[5];
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b0;
    bus.req_balk = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_vec", {28'd0, bus.sensor_a, bus.sensor_b, bus.busy, bus.done}, 32'b1100);
    check("rst_in_cnt", bus.in_cnt, 0);
    check("rst_out_cnt", bus.out_cnt, 0);
    check("rst_state", bus.dbg_state, 0);
    reset = 1'b0;
    tick();
    check("idle_vec", {28'd0, bus.sensor_a, bus.sensor_b, bus.busy, bus.done}, 32'b1100);

    // entry
    run_pass(K_IN, -1, "entry");
    check("entry_in_cnt", bus.in_cnt, 1);
    check("entry_out_cnt", bus.out_cnt, 0);

    // exit with a dropped req_in during PH2
    run_pass(K_OUT, 6, "exit");
    check("exit_in_cnt", bus.in_cnt, 1);
    check("exit_out_cnt", bus.out_cnt, 1);

    // priority: all three requests select the IN sequence
    run_pass(K_ALL, -1, "prio");
    check("prio_in_cnt", bus.in_cnt, 2);
    check("prio_out_cnt", bus.out_cnt, 1);

    // balk changes no tally
    run_pass(K_BALK, -1, "balk");
    check("balk_in_cnt", bus.in_cnt, 2);
    check("balk_out_cnt", bus.out_cnt, 1);

    // back-to-back passes with req_in held, counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_in = 1'b1;
    tick();
    for (int k = 1; k <= 256; k++) begin
      for (int i = 0; i < 14; i++) tick();
      check($sformatf("b2b_done_%0d", k), bus.done, 1);
      check($sformatf("b2b_cnt_%0d", k), bus.in_cnt, k % 256);
      if (k == 256) bus.req_in = 1'b0;
      tick();
      if (k < 256) begin
        check($sformatf("b2b_ph1_%0d", k), {bus.sensor_a, bus.sensor_b, bus.busy, bus.done}, 4'b0110);
      end else begin
        check("b2b_end", {bus.sensor_a, bus.sensor_b, bus.busy, bus.done}, 4'b1100);
      end
    end
    check("b2b_wrap", bus.in_cnt, 0);

    // reset mid-pass during PH2
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_ph2", {bus.sensor_a, bus.sensor_b, bus.busy}, 3'b001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_vec", {bus.sensor_a, bus.sensor_b, bus.busy, bus.done}, 4'b1100);
    check("mid_rst_in_cnt", bus.in_cnt, 0);
    for (int i = 0; i < 20; i++) tick();
    check("mid_no_done", bus.done, 0);
    run_pass(K_IN, -1, "fresh");
    check("fresh_in_cnt", bus.in_cnt, 1);

    // scoreboard: 3 entries, 1 balk, 1 exit; track occupancy in_cnt-out_cnt
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    kinds = '{K_IN, K_IN, K_IN, K_BALK, K_OUT};
    exp_q = {8'd1, 8'd2, 8'd3, 8'd3, 8'd2};
    foreach (kinds[i]) begin
      logic [CNT_W-1:0] occ;
      logic [CNT_W-1:0] exp_occ;
      run_pass(kinds[i], -1, $sformatf("sb%0d", i));
      occ = bus.in_cnt - bus.out_cnt;
      exp_occ = exp_q.pop_front();
      check($sformatf("sb_occ_%0d", i), occ, exp_occ);
    end
    check("sb_in_cnt", bus.in_cnt, 3);
    check("sb_out_cnt", bus.out_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
